ddram_arb: RTL and testbench



---
 rtl/ddram_arb.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ddram_arb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_arb.sv
// ---------------------------------------------------------------------------
// ddram_arb
//
// Shares the single HPS DDRAM Avalon-MM port between three independent
// clients (cartridge loader writes, sprite/fix fetch reads, CPU-side reads).
// Each client uses a toggle req/ack handshake: it is pending while
// pN_req != pN_ack.
//
// One transaction is in flight at a time. Clients are granted round-robin
// from a 2-bit pointer that names the highest-priority client.
//
// Optional feature, selected by the macro DDRAM_ARB_P0PRIO_EN:
//   defined     - client 0 has absolute priority and does not move the
//                 pointer; clients 1 and 2 round-robin between themselves.
//   not defined - pure three-way round-robin.
//
// Ports
//   DDRAM_CLK         sole clock, rising edge
//   nRESET            asynchronous active-low reset
//   DDRAM_BUSY        Avalon waitrequest
//   DDRAM_BURSTCNT    always 1
//   DDRAM_ADDR        {BASE, granted word address}
//   DDRAM_DOUT        read data from DDRAM
//   DDRAM_DOUT_READY  read data valid
//   DDRAM_RD/WE       read / write command
//   DDRAM_DIN         write data
//   DDRAM_BE          byte enables (8'hFF on reads)
//   pN_addr           client byte address, bits [2:0] ignored
//   pN_we             1 = write, 0 = read
//   pN_din/pN_be      client write data / byte enables
//   pN_req            client request toggle
//   pN_ack            completion toggle back to the client
//   pN_dout           read data, valid when pN_ack == pN_req
// ---------------------------------------------------------------------------
module ddram_arb #(
    parameter logic [3:0] BASE = 4'b0011
) (
    input  logic        DDRAM_CLK,
    input  logic        nRESET,

    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,

    input  logic [27:0] p0_addr,
    input  logic        p0_we,
    input  logic [63:0] p0_din,
    input  logic [7:0]  p0_be,
    input  logic        p0_req,
    output logic        p0_ack,
    output logic [63:0] p0_dout,

    input  logic [27:0] p1_addr,
    input  logic        p1_we,
    input  logic [63:0] p1_din,
    input  logic [7:0]  p1_be,
    input  logic        p1_req,
    output logic        p1_ack,
    output logic [63:0] p1_dout,

    input  logic [27:0] p2_addr,
    input  logic        p2_we,
    input  logic [63:0] p2_din,
    input  logic [7:0]  p2_be,
    input  logic        p2_req,
    output logic        p2_ack,
    output logic [63:0] p2_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RDW  = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        rd_q, rd_d;
    logic        we_q, we_d;
    logic        wrOp_q, wrOp_d;
    logic [24:0] addr_q, addr_d;
    logic [63:0] din_q, din_d;
    logic [7:0]  be_q, be_d;
    logic [63:0] rdata_q, rdata_d;
    logic [2:0]  ack_q, ack_d;
    logic [63:0] dout_q [3];
    logic [63:0] dout_d [3];

    // Client inputs gathered into arrays so the grant index can select them.
    logic [24:0] cAddr [3];
    logic [63:0] cDin  [3];
    logic [7:0]  cBe   [3];
    logic [2:0]  cWe;
    logic [2:0]  cReq;
    logic [2:0]  pending;
    logic        unusedAddrBits;

    assign cAddr[0] = p0_addr[27:3];
    assign cAddr[1] = p1_addr[27:3];
    assign cAddr[2] = p2_addr[27:3];
    assign cDin[0]  = p0_din;
    assign cDin[1]  = p1_din;
    assign cDin[2]  = p2_din;
    assign cBe[0]   = p0_be;
    assign cBe[1]   = p1_be;
    assign cBe[2]   = p2_be;
    assign cWe      = {p2_we, p1_we, p0_we};
    assign cReq     = {p2_req, p1_req, p0_req};
    assign pending  = cReq ^ ack_q;

    // Byte offset within a 64-bit word has no meaning on this port.
    assign unusedAddrBits = ^{p0_addr[2:0], p1_addr[2:0], p2_addr[2:0]};

    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin pick: scan ptr+2 down to ptr so the candidate closest to
    // the pointer is the last one written and therefore wins.
    logic       grantValid;
    logic [1:0] grantIdx;
    logic [2:0] candSum;
    logic [1:0] cand;

    always_comb begin
        grantValid = 1'b0;
        grantIdx   = 2'd0;
        candSum    = 3'd0;
        cand       = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            candSum = {1'b0, ptr_q} + 3'(i);
            cand    = (candSum >= 3'd3) ? 2'(candSum - 3'd3) : candSum[1:0];
            if (pending[cand]) begin
                grantValid = 1'b1;
                grantIdx   = cand;
            end
        end
`ifdef DDRAM_ARB_P0PRIO_EN
        if (pending[0]) begin
            grantValid = 1'b1;
            grantIdx   = 2'd0;
        end
`endif
    end

    // Transaction sequencer: grant and latch the command in IDLE, hold it
    // through waitrequest in CMD, wait for read data in RDW, and hand the
    // result back in ACK.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        rd_d    = rd_q;
        we_d    = we_q;
        wrOp_d  = wrOp_q;
        addr_d  = addr_q;
        din_d   = din_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    gnt_d   = grantIdx;
                    addr_d  = cAddr[grantIdx];
                    din_d   = cDin[grantIdx];
                    wrOp_d  = cWe[grantIdx];
                    be_d    = cWe[grantIdx] ? cBe[grantIdx] : 8'hFF;
                    rd_d    = ~cWe[grantIdx];
                    we_d    = cWe[grantIdx];
                    state_d = CMD;
`ifdef DDRAM_ARB_P0PRIO_EN
                    // Client 0 grants leave the p1/p2 rotation untouched.
                    if (grantIdx != 2'd0) begin
                        ptr_d = nextIdx(grantIdx);
                    end
`else
                    ptr_d = nextIdx(grantIdx);
`endif
                end
            end
            CMD: begin
                if (!DDRAM_BUSY) begin
                    rd_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = wrOp_q ? ACK : RDW;
                end
            end
            RDW: begin
                if (DDRAM_DOUT_READY) begin
                    rdata_d = DDRAM_DOUT;
                    state_d = ACK;
                end
            end
            ACK: begin
                // Ack flips rather than copying req, so a client that toggled
                // again while in flight is still pending afterwards. Read data
                // is released on the same edge so it is valid with the ack.
                ack_d[gnt_q] = ~ack_q[gnt_q];
                if (!wrOp_q) begin
                    dout_d[gnt_q] = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; reset abandons any transaction at once.
    always_ff @(posedge DDRAM_CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 2'd0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            wrOp_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            wrOp_q  <= wrOp_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            for (int i = 0; i < 3; i++) begin
                dout_q[i] <= dout_d[i];
            end
        end
    end

    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = {BASE, addr_q};
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;
    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = we_q;

    assign p0_ack  = ack_q[0];
    assign p1_ack  = ack_q[1];
    assign p2_ack  = ack_q[2];
    assign p0_dout = dout_q[0];
    assign p1_dout = dout_q[1];
    assign p2_dout = dout_q[2];

endmodule

// File: tb/tb_ddram_arb.sv
// ---------------------------------------------------------------------------
// tb_ddram_arb
//
// Directed steps (reset, single write, stalled read, reset mid-read, grant
// ordering) followed by three randomized clients running concurrently
// against a DDRAM responder with random waitrequest and read latency.
// Read data is predicted from a per-client memory model kept here.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRESET;

    // DDRAM side: either driven directly by the directed steps or by the
    // automatic responder below.
    logic        autoRsp, autoBusyEn;
    logic        manBusy, manReady;
    logic [63:0] manData;
    logic        autoBusy, autoReady;
    logic [63:0] autoData;
    logic        ddramBusy, ddramReady;
    logic [63:0] ddramDout;
    assign ddramBusy  = autoRsp ? autoBusy  : manBusy;
    assign ddramReady = autoRsp ? autoReady : manReady;
    assign ddramDout  = autoRsp ? autoData  : manData;

    logic [7:0]  ddramBurst;
    logic [28:0] ddramAddr;
    logic        ddramRd, ddramWe;
    logic [63:0] ddramDin;
    logic [7:0]  ddramBe;

    logic [27:0] pAddr [3];
    logic [63:0] pDin  [3];
    logic [7:0]  pBe   [3];
    logic [2:0]  pWe;
    logic [2:0]  pReq;
    logic        p0Ack, p1Ack, p2Ack;
    logic [63:0] p0Dout, p1Dout, p2Dout;

    ddram_arb dut (
        .DDRAM_CLK        (clk),
        .nRESET           (nRESET),
        .DDRAM_BUSY       (ddramBusy),
        .DDRAM_BURSTCNT   (ddramBurst),
        .DDRAM_ADDR       (ddramAddr),
        .DDRAM_DOUT       (ddramDout),
        .DDRAM_DOUT_READY (ddramReady),
        .DDRAM_RD         (ddramRd),
        .DDRAM_DIN        (ddramDin),
        .DDRAM_BE         (ddramBe),
        .DDRAM_WE         (ddramWe),
        .p0_addr (pAddr[0]), .p0_we (pWe[0]), .p0_din (pDin[0]), .p0_be (pBe[0]),
        .p0_req  (pReq[0]),  .p0_ack (p0Ack), .p0_dout (p0Dout),
        .p1_addr (pAddr[1]), .p1_we (pWe[1]), .p1_din (pDin[1]), .p1_be (pBe[1]),
        .p1_req  (pReq[1]),  .p1_ack (p1Ack), .p1_dout (p1Dout),
        .p2_addr (pAddr[2]), .p2_we (pWe[2]), .p2_din (pDin[2]), .p2_be (pBe[2]),
        .p2_req  (pReq[2]),  .p2_ack (p2Ack), .p2_dout (p2Dout)
    );

    int total = 0;
    int bad   = 0;
    int grantCount = 0;
    int grantLog [$];

    logic [63:0] mem      [logic [24:0]];
    logic [63:0] modelMem [logic [24:0]];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] initWord(input logic [24:0] a);
        return {7'h00, a, 7'h5A, a};
    endfunction

    function automatic logic [63:0] mergeBytes(input logic [63:0] old,
                                               input logic [63:0] d,
                                               input logic [7:0] be);
        logic [63:0] w;
        w = old;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
        end
        return w;
    endfunction

    function automatic logic [63:0] modelRead(input logic [24:0] a);
        return modelMem.exists(a) ? modelMem[a] : initWord(a);
    endfunction

    function automatic logic ackOf(input int c);
        case (c)
            0:       return p0Ack;
            1:       return p1Ack;
            default: return p2Ack;
        endcase
    endfunction

    function automatic logic [63:0] doutOf(input int c);
        case (c)
            0:       return p0Dout;
            1:       return p1Dout;
            default: return p2Dout;
        endcase
    endfunction

    // Present a request for client c and toggle its req.
    task automatic applyStimulus(input int c, input logic [27:0] a, input logic w,
                                 input logic [63:0] d, input logic [7:0] b);
        pAddr[c] = a;
        pWe[c]   = w;
        pDin[c]  = d;
        pBe[c]   = b;
        pReq[c]  = ~pReq[c];
    endtask

    task automatic waitAck(input int c, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (ackOf(c) === pReq[c]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitAllIdle(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if ({p2Ack, p1Ack, p0Ack} === pReq) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // One randomized client: random op, address in its own region, random
    // gap; read data must match the model, and a pending client may not be
    // passed over by more than two other transactions.
    task automatic runClient(input int c, input int n);
        logic [27:0] a;
        logic        w;
        logic [63:0] d;
        logic [7:0]  b;
        logic [63:0] expWord;
        int          startCnt;
        bit          ok;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            a = {4'(c), 16'h0000, 5'($urandom), 3'($urandom)};
            w = 1'($urandom);
            d = {$urandom, $urandom};
            b = 8'($urandom);
            expWord = modelRead(a[27:3]);
            if (w) modelMem[a[27:3]] = mergeBytes(expWord, d, b);
            startCnt = grantCount;
            applyStimulus(c, a, w, d, b);
            waitAck(c, ok);
            checkOutput($sformatf("p%0d.ackSeen", c), 64'(ok), 64'd1);
            if (!w) checkOutput($sformatf("p%0d.rdData", c), doutOf(c), expWord);
`ifndef DDRAM_ARB_P0PRIO_EN
            checkOutput($sformatf("p%0d.waitBound", c),
                        64'(grantCount - startCnt <= 3), 64'd1);
`endif
        end
    endtask

    // Automatic DDRAM responder: notes commands accepted at each edge,
    // applies writes, returns reads after 0..3 cycles, and injects random
    // waitrequest and stray DOUT_READY pulses when no read is owed.
    initial begin : responder
        logic        accRd, accWr;
        logic [24:0] accAddr;
        logic [63:0] accDin;
        logic [7:0]  accBe;
        logic        rdPend;
        int          lat;
        logic [63:0] rdWord;
        rdPend = 1'b0; lat = 0; rdWord = '0;
        autoBusy = 1'b0; autoReady = 1'b0; autoData = '0;
        forever begin
            @(negedge clk);
            accRd   = autoRsp && nRESET && ddramRd && !ddramBusy;
            accWr   = autoRsp && nRESET && ddramWe && !ddramBusy;
            accAddr = ddramAddr[24:0];
            accDin  = ddramDin;
            accBe   = ddramBe;
            @(posedge clk); #1;
            if (accRd || accWr) begin
                grantCount++;
                grantLog.push_back(int'(accAddr[24:21]));
                checkOutput("burstCnt", 64'(ddramBurst), 64'd1);
            end
            if (accWr) begin
                mem[accAddr] = mergeBytes(mem.exists(accAddr) ? mem[accAddr]
                                                               : initWord(accAddr),
                                          accDin, accBe);
            end
            if (accRd) begin
                checkOutput("rdBe", 64'(ddramBe), 64'hFF);
                rdPend = 1'b1;
                lat    = $urandom_range(0, 3);
                rdWord = mem.exists(accAddr) ? mem[accAddr] : initWord(accAddr);
            end
            autoBusy = autoBusyEn && ($urandom_range(0, 3) == 0);
            if (rdPend && lat == 0) begin
                autoReady = 1'b1;
                autoData  = rdWord;
                rdPend    = 1'b0;
            end else begin
                if (rdPend) lat--;
                autoReady = !rdPend && autoBusyEn && ($urandom_range(0, 9) == 0);
                autoData  = {$urandom, $urandom};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        logic [27:0] rdAddr;
        logic [27:0] gAddr;
        int          expOrder [4];
        int          got;
        bit          ok;

        nRESET = 1'b0;
        autoRsp = 1'b0; autoBusyEn = 1'b0;
        manBusy = 1'b0; manReady = 1'b0; manData = '0;
        pReq = '0; pWe = '0;
        for (int c = 0; c < 3; c++) begin
            pAddr[c] = '0; pDin[c] = '0; pBe[c] = '0;
        end

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.rd",    64'(ddramRd),    64'd0);
        checkOutput("rst.we",    64'(ddramWe),    64'd0);
        checkOutput("rst.burst", 64'(ddramBurst), 64'd1);
        checkOutput("rst.be",    64'(ddramBe),    64'd0);
        checkOutput("rst.addr",  64'(ddramAddr),  64'h0600_0000);
        checkOutput("rst.din",   ddramDin,        64'd0);
        checkOutput("rst.acks",  64'({p2Ack, p1Ack, p0Ack}), 64'd0);
        checkOutput("rst.douts", p0Dout | p1Dout | p2Dout, 64'd0);
        nRESET = 1'b1;
        @(posedge clk); #1;

        // ---- single write on p1, BUSY low ----
        applyStimulus(1, 28'h0000108, 1'b1, 64'h1122334455667788, 8'h0F);
        @(posedge clk); #1;
        checkOutput("wr.we",   64'(ddramWe),   64'd1);
        checkOutput("wr.rd",   64'(ddramRd),   64'd0);
        checkOutput("wr.addr", 64'(ddramAddr), 64'h0600_0021);
        checkOutput("wr.be",   64'(ddramBe),   64'h0F);
        checkOutput("wr.din",  ddramDin,       64'h1122334455667788);
        @(posedge clk); #1;
        checkOutput("wr.weDrop",  64'(ddramWe), 64'd0);
        checkOutput("wr.ackLate", 64'(p1Ack),   64'd0);
        @(posedge clk); #1;
        checkOutput("wr.ack", 64'(p1Ack), 64'd1);

        // ---- read on p0 with BUSY held for 5 cycles ----
        rdAddr  = 28'h0ABCDE8;
        manBusy = 1'b1;
        applyStimulus(0, rdAddr, 1'b0, 64'd0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rd.rdHold%0d", k),   64'(ddramRd),   64'd1);
            checkOutput($sformatf("rd.addrHold%0d", k), 64'(ddramAddr),
                        64'({4'b0011, rdAddr[27:3]}));
        end
        checkOutput("rd.be", 64'(ddramBe), 64'hFF);
        manBusy = 1'b0;
        @(posedge clk); #1;
        checkOutput("rd.rdDrop", 64'(ddramRd), 64'd0);
        manReady = 1'b1;
        manData  = 64'hDEADBEEF_CAFEF00D;
        @(posedge clk); #1;
        manReady = 1'b0;
        manData  = 64'h0;
        checkOutput("rd.ackEarly",  64'(p0Ack), 64'd0);
        checkOutput("rd.doutEarly", p0Dout,     64'd0);
        @(posedge clk); #1;
        checkOutput("rd.ack",       64'(p0Ack), 64'd1);
        checkOutput("rd.dout",      p0Dout,     64'hDEADBEEF_CAFEF00D);
        checkOutput("rd.otherDout", p1Dout,     64'd0);

        // ---- reset while waiting for read data ----
        applyStimulus(1, 28'h0000200, 1'b0, 64'd0, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        nRESET = 1'b0;
        pReq   = '0;
        #1;
        checkOutput("mid.rd",   64'(ddramRd), 64'd0);
        checkOutput("mid.acks", 64'({p2Ack, p1Ack, p0Ack}), 64'd0);
        checkOutput("mid.dout", p0Dout, 64'd0);
        @(posedge clk); #1;
        nRESET   = 1'b1;
        manReady = 1'b1;
        manData  = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        manReady = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid.spuriousAcks", 64'({p2Ack, p1Ack, p0Ack}), 64'd0);
        checkOutput("mid.spuriousDout", p0Dout | p1Dout | p2Dout, 64'd0);
        applyStimulus(2, 28'h2000040, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("mid.wrAckLate", 64'(p2Ack), 64'd0);
        @(posedge clk); #1;
        checkOutput("mid.wrAck", 64'(p2Ack), 64'd1);

        // ---- simultaneous requests, pointer at 0 ----
        autoRsp = 1'b1;
        grantLog.delete();
        for (int c = 0; c < 3; c++) begin
            gAddr = {4'(c), 24'h000040};
            applyStimulus(c, gAddr, 1'b0, 64'd0, 8'h00);
        end
        waitAck(0, ok);
        checkOutput("ord.p0Ack", 64'(ok), 64'd1);
        gAddr = {4'h0, 24'h000040};
        checkOutput("ord.p0Data", p0Dout, modelRead(gAddr[27:3]));
`ifdef DDRAM_ARB_P0PRIO_EN
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (grantLog.size() >= 2) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("ord.p1Granted", 64'(ok), 64'd1);
        expOrder = '{0, 1, 0, 2};
`else
        expOrder = '{0, 1, 2, 0};
`endif
        gAddr = {4'h0, 24'h000048};
        applyStimulus(0, gAddr, 1'b0, 64'd0, 8'h00);
        waitAllIdle(ok);
        checkOutput("ord.allDone", 64'(ok), 64'd1);
        checkOutput("ord.p0Data2", p0Dout, modelRead(gAddr[27:3]));
        checkOutput("ord.count", 64'(grantLog.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < grantLog.size()) ? grantLog[i] : -1;
            checkOutput($sformatf("ord.grant%0d", i), 64'(got), 64'(expOrder[i]));
        end

        // ---- pointer position after that sequence ----
        grantLog.delete();
`ifdef DDRAM_ARB_P0PRIO_EN
        applyStimulus(1, 28'h1000050, 1'b0, 64'd0, 8'h00);
        applyStimulus(2, 28'h2000050, 1'b0, 64'd0, 8'h00);
        expOrder = '{1, 2, 0, 0};
`else
        applyStimulus(0, 28'h0000050, 1'b0, 64'd0, 8'h00);
        applyStimulus(2, 28'h2000050, 1'b0, 64'd0, 8'h00);
        expOrder = '{2, 0, 0, 0};
`endif
        waitAllIdle(ok);
        checkOutput("ptr.allDone", 64'(ok), 64'd1);
        for (int i = 0; i < 2; i++) begin
            got = (i < grantLog.size()) ? grantLog[i] : -1;
            checkOutput($sformatf("ptr.grant%0d", i), 64'(got), 64'(expOrder[i]));
        end

        // ---- randomized concurrent clients ----
        autoBusyEn = 1'b1;
        fork
            runClient(0, 25);
            runClient(1, 25);
            runClient(2, 25);
        join
        waitAllIdle(ok);
        checkOutput("rand.allDone", 64'(ok), 64'd1);
        autoBusyEn = 1'b0;

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
